// File: rtl/jtag_ram_bridge_pkg.sv
// Shared definitions for the JTAG-to-RAM bridge: default widths and FSM state encodings.
package jtag_ram_bridge_pkg;

   localparam int DR_LENGTH_DEF  = 32;
   localparam int ADDR_WIDTH_DEF = 14;
   localparam int SYNC_LEN_DEF   = 3;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WR_COMMIT = 2'd1,
      RD_ISSUE  = 2'd2,
      RD_WAIT   = 2'd3
   } bridge_state_t;

endpackage

// File: rtl/jtag_ram_bridge_strobe_sync.sv
// Strobe synchronizer: SYNC_LEN flop chain plus a history flop for rising-edge detection.
// All flops reset to 1 so a strobe already high at reset release gives no edge.
module jtag_ram_bridge_strobe_sync
   import jtag_ram_bridge_pkg::*;
#(
   parameter int SYNC_LEN = SYNC_LEN_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic strobe,
   output logic rise
);

   logic [SYNC_LEN-1:0] sync_r;
   logic                hist_r;

   // shift the raw strobe through the chain and keep one stage of history
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_r <= {SYNC_LEN{1'b1}};
         hist_r <= 1'b1;
      end else begin
         sync_r <= {sync_r[SYNC_LEN-2:0], strobe};
         hist_r <= sync_r[SYNC_LEN-1];
      end
   end

   assign rise = sync_r[SYNC_LEN-1] & ~hist_r;

endmodule

// File: rtl/jtag_ram_bridge.sv
// Bridge between quasi-static JTAG registers (TCK domain) and a dual-port block RAM (clk domain).
// Optional write checksum on csum enabled by defining BRIDGE_CSUM_EN.
module jtag_ram_bridge
   import jtag_ram_bridge_pkg::*;
#(
   parameter int DR_LENGTH  = DR_LENGTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int SYNC_LEN   = SYNC_LEN_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wram_enable,
   input  logic                  rram_enable,
   input  logic [DR_LENGTH-1:0]  waddr_in,
   input  logic [DR_LENGTH-1:0]  raddr_in,
   input  logic [DR_LENGTH-1:0]  wdata_in,
   output logic [DR_LENGTH-1:0]  rdata_out,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_waddr,
   output logic [DR_LENGTH-1:0]  ram_wdata,
   output logic [ADDR_WIDTH-1:0] ram_raddr,
   input  logic [DR_LENGTH-1:0]  ram_rdata,
   output logic                  busy,
   output logic [DR_LENGTH-1:0]  csum
);

   localparam int BURST_BIT = DR_LENGTH - 1;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   bridge_state_t         state_r, state_s;
   logic                  wr_rise_s, rd_rise_s, wr_req_s, rd_req_s;
   logic                  wr_pend_r, rd_pend_r, wr_pend_s, rd_pend_s;
   logic [ADDR_WIDTH-1:0] wptr_r, rptr_r, wr_addr_r, rd_addr_r;
   logic [ADDR_WIDTH-1:0] wr_addr_new_s, rd_addr_new_s, wr_addr_sel_s, rd_addr_sel_s;
   logic [DR_LENGTH-1:0]  wr_data_r, wr_data_sel_s, rdata_r, ram_wdata_r;
   logic [ADDR_WIDTH-1:0] ram_waddr_r, ram_raddr_r;
   logic                  ram_we_r, busy_r;
   logic                  unused_s;

   jtag_ram_bridge_strobe_sync #(.SYNC_LEN(SYNC_LEN)) u_wr_sync (
      .clk(clk), .reset(reset), .strobe(wram_enable), .rise(wr_rise_s));
   jtag_ram_bridge_strobe_sync #(.SYNC_LEN(SYNC_LEN)) u_rd_sync (
      .clk(clk), .reset(reset), .strobe(rram_enable), .rise(rd_rise_s));

   assign unused_s = ^{waddr_in[DR_LENGTH-2:ADDR_WIDTH], raddr_in[DR_LENGTH-2:ADDR_WIDTH]};

   // a pending request carries the address/data captured when its edge arrived
   assign wr_addr_new_s = waddr_in[BURST_BIT] ? wptr_r : waddr_in[ADDR_WIDTH-1:0];
   assign rd_addr_new_s = raddr_in[BURST_BIT] ? rptr_r : raddr_in[ADDR_WIDTH-1:0];
   assign wr_addr_sel_s = wr_pend_r ? wr_addr_r : wr_addr_new_s;
   assign wr_data_sel_s = wr_pend_r ? wr_data_r : wdata_in;
   assign rd_addr_sel_s = rd_pend_r ? rd_addr_r : rd_addr_new_s;
   assign wr_req_s      = wr_rise_s | wr_pend_r;
   assign rd_req_s      = rd_rise_s | rd_pend_r;

   // next-state and pending-flag logic; write wins over a simultaneous read
   always_comb begin
      state_s   = state_r;
      wr_pend_s = wr_pend_r;
      rd_pend_s = rd_pend_r;
      case (state_r)
         IDLE: begin
            if (wr_req_s) begin
               state_s   = WR_COMMIT;
               wr_pend_s = 1'b0;
               rd_pend_s = rd_req_s;
            end else if (rd_req_s) begin
               state_s   = RD_ISSUE;
               wr_pend_s = 1'b0;
               rd_pend_s = 1'b0;
            end else begin
               state_s   = IDLE;
               wr_pend_s = 1'b0;
               rd_pend_s = 1'b0;
            end
         end
         WR_COMMIT: begin
            wr_pend_s = wr_pend_r | wr_rise_s;
            rd_pend_s = 1'b0;
            if (rd_req_s) begin
               state_s = RD_ISSUE;
            end else begin
               state_s = IDLE;
            end
         end
         RD_ISSUE: begin
            state_s   = RD_WAIT;
            wr_pend_s = wr_pend_r | wr_rise_s;
            rd_pend_s = rd_pend_r | rd_rise_s;
         end
         RD_WAIT: begin
            state_s   = IDLE;
            wr_pend_s = wr_pend_r | wr_rise_s;
            rd_pend_s = rd_pend_r | rd_rise_s;
         end
         default: begin
            state_s   = IDLE;
            wr_pend_s = 1'b0;
            rd_pend_s = 1'b0;
         end
      endcase
   end

   // control state: FSM, pending flags, request capture and burst pointers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= IDLE;
         wr_pend_r <= 1'b0;
         rd_pend_r <= 1'b0;
         wr_addr_r <= {ADDR_WIDTH{1'b0}};
         wr_data_r <= {DR_LENGTH{1'b0}};
         rd_addr_r <= {ADDR_WIDTH{1'b0}};
         wptr_r    <= {ADDR_WIDTH{1'b0}};
         rptr_r    <= {ADDR_WIDTH{1'b0}};
      end else begin
         state_r   <= state_s;
         wr_pend_r <= wr_pend_s;
         rd_pend_r <= rd_pend_s;
         if (wr_rise_s && !wr_pend_r) begin
            wr_addr_r <= wr_addr_new_s;
            wr_data_r <= wdata_in;
         end
         if (rd_rise_s && !rd_pend_r) begin
            rd_addr_r <= rd_addr_new_s;
         end
         if (state_r == WR_COMMIT) begin
            wptr_r <= ram_waddr_r + ADDR_ONE;
         end
         if (state_r == RD_ISSUE) begin
            rptr_r <= ram_raddr_r + ADDR_ONE;
         end
      end
   end

   // registered RAM-side and JTAG-side outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ram_we_r    <= 1'b0;
         ram_waddr_r <= {ADDR_WIDTH{1'b0}};
         ram_wdata_r <= {DR_LENGTH{1'b0}};
         ram_raddr_r <= {ADDR_WIDTH{1'b0}};
         rdata_r     <= {DR_LENGTH{1'b0}};
         busy_r      <= 1'b0;
      end else begin
         ram_we_r <= (state_s == WR_COMMIT);
         busy_r   <= (state_s != IDLE);
         if (state_s == WR_COMMIT) begin
            ram_waddr_r <= wr_addr_sel_s;
            ram_wdata_r <= wr_data_sel_s;
         end
         if (state_s == RD_ISSUE) begin
            ram_raddr_r <= rd_addr_sel_s;
         end
         if (state_r == RD_WAIT) begin
            rdata_r <= ram_rdata;
         end
      end
   end

`ifdef BRIDGE_CSUM_EN
   logic [DR_LENGTH-1:0] csum_r;

   // running modulo-2^DR_LENGTH sum of committed write data
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         csum_r <= {DR_LENGTH{1'b0}};
      end else if (ram_we_r) begin
         csum_r <= csum_r + ram_wdata_r;
      end
   end

   assign csum = csum_r;
`else
   assign csum = {DR_LENGTH{1'b0}};
`endif

   assign ram_we    = ram_we_r;
   assign ram_waddr = ram_waddr_r;
   assign ram_wdata = ram_wdata_r;
   assign ram_raddr = ram_raddr_r;
   assign rdata_out = rdata_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_jtag_ram_bridge.sv
// Scoreboard bench for jtag_ram_bridge: expected writes/reads are queued at stimulus time
// and popped when the DUT pulses ram_we or finishes a read. Honours BRIDGE_CSUM_EN.
module tb_jtag_ram_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic        wram_enable, rram_enable;
   logic [31:0] waddr_in, raddr_in, wdata_in;
   logic [31:0] rdata_out, ram_wdata, ram_rdata, csum;
   logic        ram_we, busy;
   logic [13:0] ram_waddr, ram_raddr;

   logic [31:0] mem [0:16383];
   logic [45:0] wr_q [$];
   logic [31:0] rd_q [$];
   int          total = 0;
   int          bad = 0;
   int          we_cnt = 0;
   int          we_base;

   jtag_ram_bridge dut (
      .clk(clk), .reset(reset),
      .wram_enable(wram_enable), .rram_enable(rram_enable),
      .waddr_in(waddr_in), .raddr_in(raddr_in), .wdata_in(wdata_in),
      .rdata_out(rdata_out), .ram_we(ram_we), .ram_waddr(ram_waddr),
      .ram_wdata(ram_wdata), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
      .busy(busy), .csum(csum));

   always #5 clk = ~clk;

   // dual-port RAM model with one-cycle read latency
   always @(posedge clk) begin
      if (ram_we) mem[ram_waddr] <= ram_wdata;
      ram_rdata <= mem[ram_raddr];
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // write monitor: every ram_we pulse must match the head of the write queue
   always @(negedge clk) begin
      logic [45:0] e;
      if (!reset && ram_we) begin
         we_cnt++;
         if (wr_q.size() == 0) begin
            check_val("we_unexp", {31'd0, ram_we}, 32'd0);
         end else begin
            e = wr_q.pop_front();
            check_val("waddr", {18'd0, ram_waddr}, {18'd0, e[45:32]});
            check_val("wdata", ram_wdata, e[31:0]);
         end
      end
   end

   task automatic wait_done(input string tag);
      logic seen = 1'b0;
      logic done = 1'b0;
      for (int n = 0; n < 40 && !done; n++) begin
         @(negedge clk);
         if (busy) seen = 1'b1;
         else if (seen) done = 1'b1;
      end
      check_val(tag, {31'd0, done}, 32'd1);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [13:0] ea);
      wr_q.push_back({ea, d});
      waddr_in = a;
      wdata_in = d;
      wram_enable = 1'b1;
      repeat (10) @(negedge clk);
      wram_enable = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic do_read(input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] e;
      rd_q.push_back(exp);
      raddr_in = a;
      rram_enable = 1'b1;
      wait_done("rd_timeout");
      e = rd_q.pop_front();
      check_val("rdata", rdata_out, e);
      rram_enable = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [13:0] burst_a [4];
      burst_a[0] = 14'h3FFE; burst_a[1] = 14'h3FFF;
      burst_a[2] = 14'h0000; burst_a[3] = 14'h0001;
      reset = 1'b1;
      wram_enable = 1'b0; rram_enable = 1'b0;
      waddr_in = 32'd0; raddr_in = 32'd0; wdata_in = 32'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_val("rst_we", {31'd0, ram_we}, 32'd0);
      check_val("rst_busy", {31'd0, busy}, 32'd0);
      check_val("rst_rdata", rdata_out, 32'd0);
      check_val("rst_waddr", {18'd0, ram_waddr}, 32'd0);
      check_val("rst_wdata", ram_wdata, 32'd0);
      check_val("rst_raddr", {18'd0, ram_raddr}, 32'd0);
      check_val("rst_csum", csum, 32'd0);

      // single write: pulse must appear SYNC_LEN+1 clks after the toggle
      wr_q.push_back({14'h0010, 32'hDEADBEEF});
      waddr_in = 32'h0000_0010;
      wdata_in = 32'hDEADBEEF;
      wram_enable = 1'b1;
      repeat (3) @(negedge clk);
      check_val("we_early", {31'd0, ram_we}, 32'd0);
      @(negedge clk);
      check_val("we_lat", {31'd0, ram_we}, 32'd1);
      repeat (8) @(negedge clk);
      check_val("we_pulse", {31'd0, ram_we}, 32'd0);
      check_val("waddr_hold", {18'd0, ram_waddr}, 32'h0010);
      wram_enable = 1'b0;
      repeat (4) @(negedge clk);

      do_read(32'h0000_0010, 32'hDEADBEEF);
      repeat (10) @(negedge clk);
      check_val("rd_hold", rdata_out, 32'hDEADBEEF);
      do_write(32'h0000_0010, 32'h1234_5678, 14'h0010);
      check_val("rd_hold_wr", rdata_out, 32'hDEADBEEF);

      // burst writes/reads wrapping at the top of the address space
      do_write(32'h0000_3FFD, 32'h0, 14'h3FFD);
      for (int i = 0; i < 4; i++) do_write(32'h8000_0000, 32'(i + 1), burst_a[i]);
      do_read(32'h0000_3FFD, 32'h0);
      for (int i = 0; i < 4; i++) do_read(32'h8000_0000, 32'(i + 1));
      do_read(32'h0000_0000, 32'h3);

      // simultaneous requests: write commits before the read
      do_write(32'h0000_0020, 32'h1111_1111, 14'h0020);
      wr_q.push_back({14'h0020, 32'h5A5A5A5A});
      waddr_in = 32'h20; raddr_in = 32'h20; wdata_in = 32'h5A5A5A5A;
      wram_enable = 1'b1; rram_enable = 1'b1;
      wait_done("raw_timeout");
      check_val("raw_rdata", rdata_out, 32'h5A5A5A5A);
      wram_enable = 1'b0; rram_enable = 1'b0;
      repeat (6) @(negedge clk);

      // reset during a write pulse, strobe held high across reset release
      waddr_in = 32'h200; wdata_in = 32'hCAFE_0000;
      wram_enable = 1'b1;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
      check_val("we_pre_rst", {31'd0, ram_we}, 32'd1);
      reset = 1'b1;
      #1;
      check_val("we_abort", {31'd0, ram_we}, 32'd0);
      repeat (3) @(negedge clk);
      we_base = we_cnt;
      reset = 1'b0;
      repeat (12) @(negedge clk);
      check_val("no_false_we", we_cnt, we_base);
      check_val("rst2_busy", {31'd0, busy}, 32'd0);
      check_val("rst2_rdata", rdata_out, 32'd0);
      wram_enable = 1'b0;
      repeat (4) @(negedge clk);
      do_write(32'h8000_0000, 32'h0, 14'h0000);
      check_val("one_we", we_cnt, we_base + 1);

      do_write(32'h0000_0100, 32'hFFFF_FFFF, 14'h0100);
      do_write(32'h0000_0101, 32'h0000_0002, 14'h0101);
`ifdef BRIDGE_CSUM_EN
      check_val("csum", csum, 32'h0000_0001);
`else
      check_val("csum", csum, 32'h0000_0000);
`endif

      check_val("wr_q_left", wr_q.size(), 32'd0);
      check_val("rd_q_left", rd_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
